// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state encoding and helpers for the reaction-time session controller
package reaction_pkg;
  localparam int RAND_W = 4;
  typedef enum logic [6:0] {
    IDLE    = 7'b0000001,
    ARM     = 7'b0000010,
    DELAY   = 7'b0000100,
    MEASURE = 7'b0001000,
    RESULT  = 7'b0010000,
    WAIT    = 7'b0100000,
    DONE    = 7'b1000000
  } state_e;
  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/reaction_session_ctrl_if.sv
// reaction_session_ctrl_if: button/LFSR inputs and display/LED outputs of the session controller
interface reaction_session_ctrl_if #(
  parameter int MAX_MS      = 1000,
  parameter int TRIALS_LOG2 = 2
);
  import reaction_pkg::*;
  localparam int MSW = $clog2(MAX_MS + 1);
  logic                 start_btn;
  logic                 stop_btn;
  logic                 clear_btn;
  logic [RAND_W-1:0]    rand_val;
  logic                 led_stim;
  logic                 busy;
  logic [MSW-1:0]       result_ms;
  logic                 result_valid;
  logic                 false_start;
  logic [TRIALS_LOG2:0] trial_idx;
  logic [MSW-1:0]       best_ms;
  logic [MSW-1:0]       avg_ms;
  logic                 session_done;
  modport master (
    output start_btn, stop_btn, clear_btn, rand_val,
    input  led_stim, busy, result_ms, result_valid, false_start, trial_idx, best_ms, avg_ms, session_done
  );
  modport slave (
    input  start_btn, stop_btn, clear_btn, rand_val,
    output led_stim, busy, result_ms, result_valid, false_start, trial_idx, best_ms, avg_ms, session_done
  );
endinterface

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler, one-cycle tick at terminal count, restartable
module ms_tick_gen #(
  parameter int CLK_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;
  localparam logic [W-1:0] TC = W'(CLK_PER_MS - 1);
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == TC;
  // count 0..CLK_PER_MS-1, realigned to 0 whenever the controller changes state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= restart || tick ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl: multi-trial reaction-time session sequencer with best/average tracking
module reaction_session_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_PER_MS    = 100000,
  parameter int DELAY_UNIT_MS = 250,
  parameter int MAX_MS        = 1000,
  parameter int TRIALS_LOG2   = 2
) (
  input logic clk,
  input logic rst_n,
  reaction_session_ctrl_if.slave bus
);
  localparam int MSW = $clog2(MAX_MS + 1);
  localparam int DW  = $clog2(16 * DELAY_UNIT_MS + 1);
  localparam int CW  = DW > MSW ? DW : MSW;
  localparam int SW  = MSW + TRIALS_LOG2;
  localparam int TW  = TRIALS_LOG2 + 1;
  localparam logic [TW-1:0]  TRIALS = TW'(1 << TRIALS_LOG2);
  localparam logic [MSW-1:0] MAX_V  = MSW'(MAX_MS);
  localparam logic [CW-1:0]  MAX_C  = CW'(MAX_MS);
  state_e         state_q, state_d;
  logic           tick, restart;
  logic [CW-1:0]  ms_q, ms_inc, delay_q;
  logic [MSW-1:0] result_q, best_q, val;
  logic [SW-1:0]  sum_q;
  logic [TW-1:0]  trial_q;
  logic           fs_q;
  assign ms_inc  = ms_q + CW'(1);
  assign restart = state_d != state_q;
  assign val     = state_q == DELAY ? MAX_V : MSW'(tick ? ms_inc : ms_q);
  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state; clear overrides everything, unknown encodings fall back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_btn) state_d = ARM;
      ARM:     state_d = DELAY;
      DELAY:   if (bus.stop_btn || (tick && ms_inc == delay_q)) state_d = bus.stop_btn ? RESULT : MEASURE;
      MEASURE: if (bus.stop_btn || (tick && ms_inc == MAX_C)) state_d = RESULT;
      RESULT:  state_d = trial_q == TRIALS ? DONE : WAIT;
      WAIT:    if (bus.start_btn) state_d = ARM;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (bus.clear_btn) state_d = IDLE;
  end
  // ms counter, delay latch and session accumulators; results land as RESULT is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_q     <= '0;
      delay_q  <= '0;
      result_q <= '0;
      best_q   <= MAX_V;
      sum_q    <= '0;
      trial_q  <= '0;
      fs_q     <= 1'b0;
    end else begin
      ms_q <= restart ? '0 : ms_q + CW'(tick);
      if (state_q == ARM) delay_q <= CW'(bus.rand_val) * CW'(DELAY_UNIT_MS) + CW'(DELAY_UNIT_MS);
      if (bus.clear_btn) begin
        result_q <= '0;
        fs_q     <= 1'b0;
        trial_q  <= '0;
        sum_q    <= '0;
        best_q   <= MAX_V;
      end else if (state_q == IDLE && bus.start_btn) begin
        sum_q   <= '0;
        best_q  <= MAX_V;
        trial_q <= '0;
      end else if (state_d == RESULT) begin
        result_q <= val;
        fs_q     <= state_q == DELAY;
        sum_q    <= sum_q + SW'(val);
        best_q   <= MSW'(umin(32'(best_q), 32'(val)));
        trial_q  <= trial_q + TW'(1);
      end
    end
  end
  // outputs decoded purely from state and registers
  always_comb begin
    bus.led_stim     = state_q == MEASURE;
    bus.busy         = state_q inside {ARM, DELAY, MEASURE, RESULT};
    bus.result_valid = state_q == RESULT;
    bus.session_done = state_q == DONE;
    bus.result_ms    = result_q;
    bus.false_start  = fs_q;
    bus.trial_idx    = trial_q;
    bus.best_ms      = best_q;
    bus.avg_ms       = MSW'(sum_q >> TRIALS_LOG2);
  end
endmodule

// File: tb/tb_reaction_session_ctrl.sv
// tb_reaction_session_ctrl: scoreboard bench for the reaction session controller
module tb_reaction_session_ctrl;
  localparam int CPM = 4;
  localparam int DU  = 2;
  localparam int MAX = 20;
  localparam int TL2 = 1;
  typedef struct { int v; int fs; int tr; } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0, errs = 0;
  int   rv_cnt = 0, led_cnt = 0;
  int   exp_trial = 0, exp_sum = 0, exp_best = MAX;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  reaction_session_ctrl_if #(.MAX_MS(MAX), .TRIALS_LOG2(TL2)) bus ();
  reaction_session_ctrl #(.CLK_PER_MS(CPM), .DELAY_UNIT_MS(DU), .MAX_MS(MAX), .TRIALS_LOG2(TL2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vecs++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask
  task automatic model_clear();
    exp_trial = 0;
    exp_sum = 0;
    exp_best = MAX;
  endtask
  task automatic expect_result(input int v, input int fs);
    exp_trial++;
    exp_sum += v;
    exp_best = v < exp_best ? v : exp_best;
    sb.push_back('{v, fs, exp_trial});
  endtask
  task automatic press_start(input logic [3:0] r);
    @(negedge clk);
    bus.rand_val = r;
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.start_btn = 1'b0;
  endtask
  task automatic press_stop();
    @(negedge clk);
    bus.stop_btn = 1'b1;
    @(negedge clk);
    bus.stop_btn = 1'b0;
  endtask
  task automatic press_clear();
    @(negedge clk);
    bus.clear_btn = 1'b1;
    @(negedge clk);
    bus.clear_btn = 1'b0;
    model_clear();
  endtask
  task automatic wait_led(output int n);
    n = 0;
    while (!bus.led_stim && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic trial_stop(input logic [3:0] r, input int ticks);
    int n;
    press_start(r);
    wait_led(n);
    chk("stim_lat", n, (int'(r) + 1) * DU * CPM + 1);
    expect_result(ticks, 0);
    repeat (ticks * CPM + 1) @(negedge clk);
    press_stop();
  endtask
  // scoreboard consumer: every result_valid pulse pops one expected trial result
  always @(negedge clk) begin
    if (bus.led_stim) led_cnt++;
    if (rst_n && bus.result_valid) begin
      rv_cnt++;
      if (sb.size() == 0) chk("rv_unexpected", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("res_ms", bus.result_ms, e.v);
        chk("res_fs", bus.false_start, e.fs);
        chk("res_trial", bus.trial_idx, e.tr);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n, rv0;
    bus.start_btn = 0;
    bus.stop_btn = 0;
    bus.clear_btn = 0;
    bus.rand_val = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_best", bus.best_ms, MAX);
    chk("rst_trial", bus.trial_idx, 0);
    chk("rst_result", bus.result_ms, 0);
    chk("rst_led", bus.led_stim, 0);
    chk("rst_done", bus.session_done, 0);
    chk("rst_avg", bus.avg_ms, 0);
    chk("rst_rv", bus.result_valid, 0);
    rst_n = 1'b1;
    model_clear();
    rv0 = rv_cnt;
    trial_stop(3, 5);
    @(negedge clk);
    chk("wait_busy", bus.busy, 0);
    chk("wait_trial", bus.trial_idx, exp_trial);
    chk("pulse_cnt", rv_cnt - rv0, 1);
    press_stop();
    @(negedge clk);
    chk("wait_stop_ign", bus.busy, 0);
    chk("wait_stop_rv", rv_cnt - rv0, 1);
    trial_stop(1, 12);
    @(negedge clk);
    chk("done_flag", bus.session_done, 1);
    chk("done_best", bus.best_ms, exp_best);
    chk("done_avg", bus.avg_ms, exp_sum >> TL2);
    chk("done_trial", bus.trial_idx, exp_trial);
    press_start(2);
    repeat (2) @(negedge clk);
    chk("done_start_ign", bus.session_done, 1);
    chk("done_start_busy", bus.busy, 0);
    press_clear();
    chk("clr_trial", bus.trial_idx, 0);
    chk("clr_best", bus.best_ms, MAX);
    chk("clr_result", bus.result_ms, 0);
    chk("clr_done", bus.session_done, 0);
    press_start(0);
    led_cnt = 0;
    repeat (3) @(negedge clk);
    expect_result(MAX, 1);
    press_stop();
    chk("fs_flag", bus.false_start, 1);
    @(negedge clk);
    chk("fs_led", led_cnt, 0);
    expect_result(MAX, 0);
    press_start(1);
    wait_led(n);
    chk("stim_lat", n, 2 * DU * CPM + 1);
    n = 0;
    while (!bus.result_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_lat", n, MAX * CPM);
    @(negedge clk);
    chk("to_fs", bus.false_start, 0);
    chk("to_done", bus.session_done, 1);
    chk("to_best", bus.best_ms, exp_best);
    chk("to_avg", bus.avg_ms, exp_sum >> TL2);
    press_clear();
    trial_stop(0, 3);
    @(negedge clk);
    chk("c_trial", bus.trial_idx, exp_trial);
    press_start(2);
    wait_led(n);
    chk("c_led_on", bus.led_stim, 1);
    repeat (5) @(negedge clk);
    press_clear();
    chk("mclr_led", bus.led_stim, 0);
    chk("mclr_busy", bus.busy, 0);
    chk("mclr_trial", bus.trial_idx, 0);
    chk("mclr_best", bus.best_ms, MAX);
    chk("mclr_result", bus.result_ms, 0);
    trial_stop(1, 7);
    @(negedge clk);
    chk("c2_trial", bus.trial_idx, exp_trial);
    @(negedge clk);
    bus.clear_btn = 1'b1;
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.clear_btn = 1'b0;
    bus.start_btn = 1'b0;
    model_clear();
    chk("cs_busy", bus.busy, 0);
    chk("cs_trial", bus.trial_idx, 0);
    @(negedge clk);
    chk("cs_idle", bus.busy, 0);
    trial_stop(2, 4);
    @(negedge clk);
    chk("r_pre_result", bus.result_ms, 4);
    press_start(3);
    repeat (5) @(negedge clk);
    chk("r_in_delay", bus.busy, 1);
    rv0 = rv_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_result", bus.result_ms, 0);
    chk("arst_trial", bus.trial_idx, 0);
    chk("arst_best", bus.best_ms, MAX);
    chk("arst_fs", bus.false_start, 0);
    chk("arst_rv", bus.result_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    chk("arst_no_rv", rv_cnt, rv0);
    trial_stop(3, 9);
    @(negedge clk);
    chk("post_trial", bus.trial_idx, exp_trial);
    chk("post_best", bus.best_ms, exp_best);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
